// File: rtl/envelope_shaper_pkg.sv
// -----------------------------------------------------------------------------
// envelope_shaper_pkg
// Shared definitions for the ADSR envelope shaper:
//   - FSM state encoding (numeric values are visible on o_state)
//   - bit positions of the A/D/S/R fields inside an instrument ROM word
//   - envelope ceiling and the per-tick step helper
// -----------------------------------------------------------------------------
package envelope_shaper_pkg;

  localparam logic [2:0] ENV_IDLE    = 3'd0;
  localparam logic [2:0] ENV_FETCH   = 3'd1;
  localparam logic [2:0] ENV_WAIT    = 3'd2;
  localparam logic [2:0] ENV_ATTACK  = 3'd3;
  localparam logic [2:0] ENV_DECAY   = 3'd4;
  localparam logic [2:0] ENV_SUSTAIN = 3'd5;
  localparam logic [2:0] ENV_RELEASE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = ENV_IDLE,
    ST_FETCH   = ENV_FETCH,
    ST_WAIT    = ENV_WAIT,
    ST_ATTACK  = ENV_ATTACK,
    ST_DECAY   = ENV_DECAY,
    ST_SUSTAIN = ENV_SUSTAIN,
    ST_RELEASE = ENV_RELEASE
  } env_state_t;

  // Instrument ROM word: [15:12] attack, [11:8] decay, [7:4] sustain, [3:0] release
  localparam int ENV_A_MSB = 15;
  localparam int ENV_A_LSB = 12;
  localparam int ENV_D_MSB = 11;
  localparam int ENV_D_LSB = 8;
  localparam int ENV_S_MSB = 7;
  localparam int ENV_S_LSB = 4;
  localparam int ENV_R_MSB = 3;
  localparam int ENV_R_LSB = 0;

  localparam logic [7:0] ENV_LEVEL_MAX = 8'd255;

  // Per-tick level step for a 4-bit rate: (rate + 1) << shift, 9 bits wide.
  function automatic logic [8:0] env_step(input logic [3:0] rate, input int shift);
    logic [8:0] base;
    base = {5'd0, rate} + 9'd1;
    return base << shift;
  endfunction

endpackage

// File: rtl/envelope_scaler.sv
// -----------------------------------------------------------------------------
// envelope_scaler
// Two-stage sample scaling pipeline: o_sample = (i_sample * i_level) >>> COEF_W.
// i_level is treated as unsigned (0..255), i_sample as two's complement.
// Latency 2 cycles, one sample per cycle throughput. o_sample only updates
// when a valid sample reaches the output and holds its value otherwise.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_sample          signed raw sample (DATA_W bits)
//   i_sample_valid    i_sample qualifier
//   i_level           unsigned envelope gain (COEF_W bits)
//   o_sample          signed scaled sample (DATA_W bits)
//   o_sample_valid    o_sample qualifier
// -----------------------------------------------------------------------------
module envelope_scaler #(
  parameter int DATA_W = 9,
  parameter int COEF_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_sample_valid,
  input  logic [COEF_W-1:0] i_level,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_sample_valid
);

  localparam int PROD_W = DATA_W + COEF_W;

  // Arithmetic shift back to sample width; the product magnitude is bounded by
  // (2^(DATA_W-1)) * (2^COEF_W - 1), so the shifted value always fits DATA_W.
  function automatic logic signed [DATA_W-1:0] scale_shift(
    input logic signed [PROD_W-1:0] prod
  );
    return DATA_W'(prod >>> COEF_W);
  endfunction

  logic signed [PROD_W-1:0] sample_ext_p0;
  logic signed [PROD_W-1:0] level_ext_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic signed [DATA_W-1:0] sample_p2;
  logic                     vld_p2;

  // Both operands widened to the product width so the multiply is exact.
  assign sample_ext_p0 = {{COEF_W{i_sample[DATA_W-1]}}, i_sample};
  assign level_ext_p0  = {{DATA_W{1'b0}}, i_level};
  assign prod_p0       = sample_ext_p0 * level_ext_p0;

  // ---- stage p0 -> p1: product register ----
  always_ff @(posedge i_clk) begin
    if (i_sample_valid) begin
      prod_p1 <= prod_p0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= i_sample_valid;
    end
  end

  // ---- stage p1 -> p2: shift and output register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_p2 <= '0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sample_p2 <= scale_shift(prod_p1);
      end
    end
  end

  assign o_sample       = sample_p2;
  assign o_sample_valid = vld_p2;

endmodule

// File: rtl/envelope_shaper.sv
// -----------------------------------------------------------------------------
// envelope_shaper
// Per-channel ADSR amplitude envelope generator and sample scaler.
// A note start (i_load) fetches the instrument's A/D/S/R word from a
// synchronous ROM, then the envelope level steps on i_tick_stb through
// ATTACK -> DECAY -> SUSTAIN, and RELEASE after i_release, ending in IDLE.
// The raw channel sample is multiplied by the current level in a 2-stage pipe.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_tick_stb              one-cycle envelope step strobe
//   i_load, i_instrument    note start and instrument index
//   i_release               one-cycle note end
//   o_rom_addr, i_rom_data  instrument ROM port (data one cycle after address)
//   i_sample, i_sample_valid   signed raw sample in
//   o_sample, o_sample_valid   signed scaled sample out (2-cycle latency)
//   o_level                 current envelope level
//   o_state                 FSM state encoding
//   o_active                high in ATTACK, DECAY, SUSTAIN or RELEASE
// -----------------------------------------------------------------------------
module envelope_shaper
  import envelope_shaper_pkg::*;
#(
  parameter logic [7:0] INSTR_BASE = 8'h00,
  parameter int         STEP_SHIFT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tick_stb,
  input  logic        i_load,
  input  logic [3:0]  i_instrument,
  input  logic        i_release,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  input  logic [8:0]  i_sample,
  input  logic        i_sample_valid,
  output logic [8:0]  o_sample,
  output logic        o_sample_valid,
  output logic [7:0]  o_level,
  output logic [2:0]  o_state,
  output logic        o_active
);

  env_state_t state_q, state_d;
  logic [7:0] level_q, level_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic [3:0] rate_a_q, rate_a_d;
  logic [3:0] rate_d_q, rate_d_d;
  logic [3:0] rate_r_q, rate_r_d;
  logic [7:0] sus_q, sus_d;

  logic [8:0]        step_a, step_d, step_r;
  logic [8:0]        attack_sum;
  logic signed [9:0] decay_diff;
  logic signed [9:0] sus_cmp;
  logic              attack_full;
  logic              decay_hit;
  logic              release_hit;

  assign step_a = env_step(rate_a_q, STEP_SHIFT);
  assign step_d = env_step(rate_d_q, STEP_SHIFT);
  assign step_r = env_step(rate_r_q, STEP_SHIFT);

  // Attack sum is 9 bits so the overshoot past 255 is visible before clamping.
  assign attack_sum  = {1'b0, level_q} + step_a;
  assign attack_full = (attack_sum >= {1'b0, ENV_LEVEL_MAX});

  // Decay is compared signed so an undershoot below zero still clamps to sustain.
  assign decay_diff = $signed({2'b00, level_q}) - $signed({1'b0, step_d});
  assign sus_cmp    = $signed({2'b00, sus_q});
  assign decay_hit  = (decay_diff <= sus_cmp);

  assign release_hit = ({1'b0, level_q} <= step_r);

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    rom_addr_d = rom_addr_q;
    rate_a_d   = rate_a_q;
    rate_d_d   = rate_d_q;
    rate_r_d   = rate_r_q;
    sus_d      = sus_q;

    // A note start overrides release and tick in every state.
    if (i_load) begin
      rom_addr_d = INSTR_BASE + {4'd0, i_instrument};
      level_d    = 8'd0;
      state_d    = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_FETCH: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          rate_a_d = i_rom_data[ENV_A_MSB:ENV_A_LSB];
          rate_d_d = i_rom_data[ENV_D_MSB:ENV_D_LSB];
          rate_r_d = i_rom_data[ENV_R_MSB:ENV_R_LSB];
          sus_d    = {i_rom_data[ENV_S_MSB:ENV_S_LSB], i_rom_data[ENV_S_MSB:ENV_S_LSB]};
          state_d  = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (i_release) begin
            state_d = ST_RELEASE;
          end else if (i_tick_stb) begin
            if (attack_full) begin
              level_d = ENV_LEVEL_MAX;
              state_d = ST_DECAY;
            end else begin
              level_d = attack_sum[7:0];
            end
          end
        end
        ST_DECAY: begin
          if (i_release) begin
            state_d = ST_RELEASE;
          end else if (i_tick_stb) begin
            if (decay_hit) begin
              level_d = sus_q;
              state_d = ST_SUSTAIN;
            end else begin
              level_d = decay_diff[7:0];
            end
          end
        end
        ST_SUSTAIN: begin
          if (i_release) begin
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (i_tick_stb) begin
            if (release_hit) begin
              level_d = 8'd0;
              state_d = ST_IDLE;
            end else begin
              level_d = level_q - step_r[7:0];
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      level_q    <= 8'd0;
      rom_addr_q <= INSTR_BASE;
      rate_a_q   <= 4'd0;
      rate_d_q   <= 4'd0;
      rate_r_q   <= 4'd0;
      sus_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      rom_addr_q <= rom_addr_d;
      rate_a_q   <= rate_a_d;
      rate_d_q   <= rate_d_d;
      rate_r_q   <= rate_r_d;
      sus_q      <= sus_d;
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_level    = level_q;
  assign o_state    = state_q;
  assign o_active   = (state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                      (state_q == ST_SUSTAIN) || (state_q == ST_RELEASE);

  envelope_scaler #(
    .DATA_W (9),
    .COEF_W (8)
  ) u_scaler (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .i_level        (level_q),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid)
  );

endmodule

// File: tb/tb_envelope_shaper.sv
module tb_envelope_shaper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick, load, rel;
  logic [3:0]  instr;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [8:0]  sample_in;
  logic        sv_in;
  logic [8:0]  sample_out;
  logic        so_valid;
  logic [7:0]  level;
  logic [2:0]  state;
  logic        active;

  always #5 clk = ~clk;

  envelope_shaper #(
    .INSTR_BASE (8'h00),
    .STEP_SHIFT (2)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_tick_stb     (tick),
    .i_load         (load),
    .i_instrument   (instr),
    .i_release      (rel),
    .o_rom_addr     (rom_addr),
    .i_rom_data     (rom_data),
    .i_sample       (sample_in),
    .i_sample_valid (sv_in),
    .o_sample       (sample_out),
    .o_sample_valid (so_valid),
    .o_level        (level),
    .o_state        (state),
    .o_active       (active)
  );

  // Synchronous instrument ROM (environment, not the model)
  logic [15:0] rom [0:255];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int errors = 0;
  int checks = 0;
  int out_count = 0;
  int exp_q[$];

  task automatic chk(input string name, input integer got, input integer exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- Reference model (spec-level) ----------------
  // phase numbers match the visible o_state encoding
  int m_phase, m_level, m_addr, m_a, m_d, m_s, m_r;

  function automatic int stepv(input int rate);
    return (rate + 1) * 4;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_level = 0; m_addr = 0;
    m_a = 0; m_d = 0; m_s = 0; m_r = 0;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    int sus;
    if (load) begin
      m_addr  = (0 + instr) % 256;
      m_level = 0;
      m_phase = 1;
    end else begin
      case (m_phase)
        1: m_phase = 2;
        2: begin
          w = rom[m_addr];
          m_a = w[15:12]; m_d = w[11:8]; m_s = w[7:4]; m_r = w[3:0];
          m_phase = 3;
        end
        3, 4, 5: begin
          if (rel) m_phase = 6;
          else if (tick) begin
            if (m_phase == 3) begin
              if (m_level + stepv(m_a) >= 255) begin
                m_level = 255; m_phase = 4;
              end else m_level = m_level + stepv(m_a);
            end else if (m_phase == 4) begin
              sus = m_s * 17;
              if (m_level - stepv(m_d) <= sus) begin
                m_level = sus; m_phase = 5;
              end else m_level = m_level - stepv(m_d);
            end
          end
        end
        6: begin
          if (tick) begin
            if (m_level <= stepv(m_r)) begin
              m_level = 0; m_phase = 0;
            end else m_level = m_level - stepv(m_r);
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: record the scoreboard expectation, advance the model,
  // clock the DUT, compare architectural state, clear one-cycle strobes.
  task automatic cyc();
    int s;
    if (sv_in) begin
      s = $signed(sample_in);
      exp_q.push_back((s * m_level) >>> 8);
    end
    model_edge();
    @(posedge clk);
    #1;
    chk("state", state, m_phase);
    chk("level", level, m_level);
    chk("rom_addr", rom_addr, m_addr);
    chk("active", active, (m_phase >= 3) ? 1 : 0);
    load = 1'b0; rel = 1'b0; tick = 1'b0; sv_in = 1'b0;
  endtask

  // Monitor: every presented output sample is matched against the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && so_valid === 1'b1) begin
      out_count++;
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sample_unexpected: got %0d expected none at %0t", $signed(sample_out), $time);
      end else begin
        chk("sample", $signed(sample_out), exp_q.pop_front());
      end
    end
  end

  initial begin
    int base_cnt;
    rst_n = 1'b0; tick = 0; load = 0; rel = 0; instr = 0; sample_in = 0; sv_in = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[1] = 16'hF382;
    rom[2] = 16'hF0F0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_level", level, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_svalid", so_valid, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_active", active, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) cyc();
    chk("idle_svalid", so_valid, 0);

    // Attack / decay / sustain / release walk with instrument 1 (F382)
    load = 1; instr = 4'd1; cyc();
    chk("load_addr", rom_addr, 1);
    chk("load_fetch", state, 1);
    cyc(); cyc();
    chk("attack_entry", state, 3);
    for (int k = 1; k <= 4; k++) begin
      tick = 1; cyc();
      chk("attack_lvl", level, (k < 4) ? 64 * k : 255);
    end
    chk("decay_entry", state, 4);
    for (int k = 1; k <= 8; k++) begin
      tick = 1; cyc();
      chk("decay_lvl", level, (k < 8) ? 255 - 16 * k : 136);
    end
    chk("sustain_entry", state, 5);
    for (int k = 0; k < 5; k++) begin
      tick = 1; cyc();
    end
    chk("sustain_hold", level, 136);
    rel = 1; cyc();
    chk("release_entry", state, 6);
    for (int k = 1; k <= 12; k++) begin
      tick = 1; cyc();
      chk("release_lvl", level, (k < 12) ? 136 - 12 * k : 0);
    end
    chk("release_idle", state, 0);
    rel = 1; cyc();
    chk("rel_in_idle", state, 0);

    // Scaling at full level: instrument 2 (A=F, S=F) sustains at 255
    load = 1; instr = 4'd2; cyc(); cyc(); cyc();
    for (int k = 0; k < 5; k++) begin
      tick = 1; cyc();
    end
    chk("sustain_255", state, 5);
    sample_in = 9'd200; sv_in = 1; cyc();
    repeat (3) cyc();
    chk("scale_pos", $signed(sample_out), 199);
    base_cnt = out_count;
    sample_in = 9'h19C; sv_in = 1; cyc();
    sample_in = 9'd50;  sv_in = 1; cyc();
    sample_in = 9'd255; sv_in = 1; cyc();
    repeat (3) cyc();
    chk("burst_count", out_count - base_cnt, 3);

    // Scaling at level 128 during attack
    load = 1; instr = 4'd1; cyc(); cyc(); cyc();
    tick = 1; cyc();
    tick = 1; cyc();
    chk("lvl_128", level, 128);
    sample_in = 9'h100; sv_in = 1; cyc();
    repeat (3) cyc();
    chk("scale_neg", $signed(sample_out), -128);

    // Retrigger during decay, then priority cases
    tick = 1; cyc();
    tick = 1; cyc();
    tick = 1; cyc();
    chk("in_decay", state, 4);
    load = 1; instr = 4'd1; cyc();
    chk("retrig_lvl", level, 0);
    chk("retrig_state", state, 1);
    cyc(); cyc();
    tick = 1; load = 1; cyc();
    chk("load_tick_lvl", level, 0);
    chk("load_tick_state", state, 1);
    cyc(); cyc();
    rel = 1; load = 1; cyc();
    chk("load_rel_state", state, 1);
    cyc(); cyc();
    tick = 1; cyc();
    tick = 1; rel = 1; cyc();
    chk("rel_tick_lvl", level, 64);
    chk("rel_tick_state", state, 6);

    // Asynchronous reset mid-operation
    load = 1; instr = 4'd1; cyc(); cyc(); cyc();
    tick = 1; cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_level", level, 0);
    chk("async_addr", rom_addr, 0);
    chk("async_active", active, 0);
    chk("async_svalid", so_valid, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      load      = ($urandom_range(39) == 0);
      instr     = 4'($urandom);
      tick      = ($urandom_range(2) == 0);
      rel       = ($urandom_range(29) == 0);
      sv_in     = ($urandom_range(1) == 0);
      sample_in = 9'($urandom);
      cyc();
    end
    repeat (4) cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
